// File: rtl/serializer.sv
// Parallel-in, serial-out shifter with valid/ready load and per-event bit advance.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module serializer #(
    parameter int BIT_DEPTH = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BIT_DEPTH-1:0]           load_data,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic                           shift_event,
    output logic                           serial_out,
    output logic                           serial_valid,
    output logic                           busy,
    output logic [$clog2(BIT_DEPTH+2)-1:0] bits_left,
    output logic                           done
);

    localparam int BL = $clog2(BIT_DEPTH + 2);
`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = BIT_DEPTH + 1;
`else
    localparam int NBITS = BIT_DEPTH;
`endif
    localparam logic [BL-1:0] N_LOAD = BL'(NBITS);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state_q, state_d;
    logic [BIT_DEPTH-1:0] data_q, data_d;
    logic [BL-1:0]        bits_left_q, bits_left_d;
    logic                 serial_out_q, serial_out_d;
    logic                 serial_valid_q, serial_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load_ready_q, load_ready_d;
`ifdef SERIALIZER_PARITY_EN
    logic                 par_q, par_d;
`endif

    function automatic logic out_bit(input logic [BIT_DEPTH-1:0] d);
        return (MSB_FIRST != 0) ? d[BIT_DEPTH-1] : d[0];
    endfunction

    function automatic logic [BIT_DEPTH-1:0] shift_one(input logic [BIT_DEPTH-1:0] d);
        return (MSB_FIRST != 0) ? {d[BIT_DEPTH-2:0], 1'b0} : {1'b0, d[BIT_DEPTH-1:1]};
    endfunction

    logic [BIT_DEPTH-1:0] shifted;

    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        bits_left_d    = bits_left_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        busy_d         = busy_q;
        load_ready_d   = load_ready_q;
        done_d         = 1'b0;
        shifted        = shift_one(data_q);
`ifdef SERIALIZER_PARITY_EN
        par_d          = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d        = SHIFT;
                    data_d         = load_data;
                    bits_left_d    = N_LOAD;
                    serial_out_d   = out_bit(load_data);
                    serial_valid_d = 1'b1;
                    busy_d         = 1'b1;
                    load_ready_d   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
                    par_d          = ^load_data;
`endif
                end
            end
            SHIFT: begin
                if (shift_event) begin
                    data_d      = shifted;
                    bits_left_d = bits_left_q - 1'b1;
                    if (bits_left_q == BL'(1)) begin
                        state_d        = IDLE;
                        serial_out_d   = 1'b0;
                        serial_valid_d = 1'b0;
                        busy_d         = 1'b0;
                        load_ready_d   = 1'b1;
                        done_d         = 1'b1;
                    end else begin
                        serial_out_d = out_bit(shifted);
`ifdef SERIALIZER_PARITY_EN
                        // Trailer bit goes out last whatever the data order.
                        if (bits_left_q == BL'(2)) serial_out_d = par_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            data_q         <= '0;
            bits_left_q    <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            load_ready_q   <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
            par_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            bits_left_q    <= bits_left_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            load_ready_q   <= load_ready_d;
`ifdef SERIALIZER_PARITY_EN
            par_q          <= par_d;
`endif
        end
    end

    assign load_ready   = load_ready_q;
    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign busy         = busy_q;
    assign bits_left    = bits_left_q;
    assign done         = done_q;

endmodule
